// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check applied at acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MERGE = 2'd2
    } lsu_state_e;

    // Misalignment, unknown width code, unsigned store, or address past the memory.
    function automatic logic access_error(input logic        we,
                                          input logic [2:0]  funct3,
                                          input logic [31:0] addr,
                                          input logic [31:0] mem_words);
        logic err;
        case (funct3)
            F3_B, F3_BU: err = 1'b0;
            F3_H, F3_HU: err = addr[0];
            F3_W:        err = (addr[1:0] != 2'b00);
            default:     err = 1'b1;
        endcase
        if (we && funct3[2]) err = 1'b1;
        if ({2'b00, addr[31:2]} >= mem_words) err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends a load lane from a word,
// and builds the write-back word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word_i[{byte_off_i, 3'b000} +: 8];
    assign lane_h = word_i[{byte_off_i[1], 4'b0000} +: 16];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data_o = {24'h0, lane_b};
            F3_H:    load_data_o = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data_o = {16'h0, lane_h};
            default: load_data_o = word_i;
        endcase
    end

    always_comb begin
        merged_o = word_i;
        case (funct3_i[1:0])
            2'b00:   merged_o[{byte_off_i, 3'b000} +: 8]    = store_data_i[7:0];
            2'b01:   merged_o[{byte_off_i[1], 4'b0000} +: 16] = store_data_i[15:0];
            default: merged_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit in front of a single-port memory with a 1-cycle
// registered read; sub-word stores are done as read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = access_error(req_we, req_funct3, req_addr, MEM_WORDS);

    // The address is live from the request while idle so the read lands in LOAD/MERGE.
    assign mem_addr       = (state_q == S_IDLE) ? {2'b00, req_addr[31:2]} : {2'b00, addr_q[31:2]};
    assign mem_write_data = (state_q == S_MERGE) ? merged_word : req_wdata;

    always_comb begin
        mem_write_en = 1'b0;
        if (!rst) begin
            if (state_q == S_MERGE)
                mem_write_en = 1'b1;
            else if (state_q == S_IDLE && accept && !req_err && req_we && req_funct3 == F3_W)
                mem_write_en = 1'b1;
        end
    end

    lsu_align u_align (
        .word_i       (mem_read_data),
        .byte_off_i   (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .merged_o     (merged_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        if (req_err || (req_we && req_funct3 == F3_W)) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= req_err;
                        end else if (!req_we) begin
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_MERGE;
                        end
                    end
                end
                S_LOAD: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_data;
                    resp_err_q   <= 1'b0;
                    state_q      <= S_IDLE;
                end
                S_MERGE: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: attached 1-cycle memory, directed cases for each access kind,
// and randomized traffic checked against a byte-arithmetic reference model.
module tb_lsu;

    localparam int unsigned WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    logic [31:0] mem [0:WORDS-1];
    logic [31:0] ref_mem [0:15];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu #(.MEM_WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always @(posedge clk) begin
        if (mem_write_en && mem_addr < WORDS) mem[mem_addr[11:0]] <= mem_write_data;
        mem_read_data <= (mem_addr < WORDS) ? mem[mem_addr[11:0]] : 32'h0;
    end

    // ---------------- reference model ----------------
    function automatic int unsigned ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = ref_size(f3);
        if (sz == 0) return 1'b1;
        if (we && f3 >= 3'b100) return 1'b1;
        if (a % sz != 0) return 1'b1;
        if (a >= 4 * WORDS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        case (ref_size(f3))
            1: begin v = v & 32'hFF;   if (f3 == 3'b000 && v >= 128)   v = v + 32'hFFFF_FF00; end
            2: begin v = v & 32'hFFFF; if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000; end
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] mask;
        int unsigned sh;
        sh = 8 * (a % 4);
        case (ref_size(f3))
            1:       mask = 32'hFF << sh;
            2:       mask = 32'hFFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // Drives one request; reports response data, latency from acceptance,
    // write pulses seen, whether one was in the acceptance cycle, and ready-low cycles.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int wr, output int wacc, output int rl);
        int k;
        rd = '0; er = 1'b0; lat = 0; wr = 0; wacc = 0; rl = 0; k = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        #1;
        while (!req_ready && k < 20) begin @(negedge clk); #1; k++; end
        if (mem_write_en) begin wr++; wacc = 1; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_write_en) wr++;
            if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; break; end
            if (!req_ready) rl++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0)    begin n_bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        n_cmp++; if (mem_write_en !== 1'b0) begin n_bad++; $display("FAIL reset_wen got=%b exp=0", mem_write_en); end
        n_cmp++; if (resp_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0)
            begin n_bad++; $display("FAIL reset_resp rdata=%h err=%b exp=0/0", resp_rdata, resp_err); end
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_loads();
        logic [31:0] rd; logic er; int lat, wr, wacc, rl;
        logic [2:0]  f3s [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] adrs [5] = '{32'h5, 32'h5, 32'h6, 32'h6, 32'h4};
        logic [31:0] exps [5] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899, 32'h8899_AABB};
        issue(1'b1, 3'b010, 32'h4, 32'h8899_AABB, rd, er, lat, wr, wacc, rl);
        n_cmp++; if (lat !== 1 || wacc !== 1) begin n_bad++; $display("FAIL sw_init lat=%0d wacc=%0d exp=1/1", lat, wacc); end
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, wr, wacc, rl);
            n_cmp++; if (rd !== exps[i] || er !== 1'b0)
                begin n_bad++; $display("FAIL load%0d rdata=%h err=%b exp=%h/0", i, rd, er, exps[i]); end
            n_cmp++; if (lat !== 2 || wr !== 0)
                begin n_bad++; $display("FAIL load%0d_timing lat=%0d wr=%0d exp=2/0", i, lat, wr); end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd; logic er; int lat, wr, wacc, rl;
        issue(1'b1, 3'b000, 32'h7, 32'h0000_0012, rd, er, lat, wr, wacc, rl);
        n_cmp++; if (lat !== 2 || wr !== 1 || wacc !== 0 || rl !== 1)
            begin n_bad++; $display("FAIL sb lat=%0d wr=%0d wacc=%0d ready_low=%0d exp=2/1/0/1", lat, wr, wacc, rl); end
        issue(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat, wr, wacc, rl);
        n_cmp++; if (rd !== 32'h1299_AABB) begin n_bad++; $display("FAIL sb_readback got=%h exp=1299aabb", rd); end
        issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, rd, er, lat, wr, wacc, rl);
        n_cmp++; if (lat !== 1 || wr !== 1 || wacc !== 1 || rd !== 32'h0 || er !== 1'b0)
            begin n_bad++; $display("FAIL sw lat=%0d wr=%0d wacc=%0d rdata=%h err=%b", lat, wr, wacc, rd, er); end
        issue(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat, wr, wacc, rl);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_readback got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_reset_merge();
        logic [31:0] rd; logic er; int lat, wr, wacc, rl; int seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h4; req_wdata = 32'h0000_5555;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++; if (mem_write_en !== 1'b0 || req_ready !== 1'b0)
            begin n_bad++; $display("FAIL merge_rst_comb wen=%b ready=%b exp=0/0", mem_write_en, req_ready); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || mem_write_en !== 1'b0)
            begin n_bad++; $display("FAIL merge_rst_out valid=%b rdata=%h err=%b wen=%b", resp_valid, resp_rdata, resp_err, mem_write_en); end
        rst = 1'b0; seen = 0;
        repeat (3) begin @(negedge clk); if (resp_valid) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL merge_rst_noresp got=%0d exp=0", seen); end
        issue(1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat, wr, wacc, rl);
        n_cmp++; if (rd !== 32'h1299_AABB) begin n_bad++; $display("FAIL merge_rst_word got=%h exp=1299aabb", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, wr, wacc, rl;
        logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b000, 3'b011, 3'b100};
        logic [31:0] adrs [5] = '{32'h2, 32'h3, 32'h4000, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            issue(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, rd, er, lat, wr, wacc, rl);
            n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || wr !== 0 || lat !== 1)
                begin n_bad++; $display("FAIL err%0d err=%b rdata=%h wr=%0d lat=%0d exp=1/0/0/1", i, er, rd, wr, lat); end
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (resp_err !== 1'b1 || resp_valid !== 1'b0)
            begin n_bad++; $display("FAIL err_hold err=%b valid=%b exp=1/0", resp_err, resp_valid); end
    endtask

    task automatic test_back_to_back();
        int got;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'hC; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(negedge clk);
        req_we = 1'b0; req_wdata = 32'h0; #1;
        n_cmp++; if (resp_valid !== 1'b1 || req_ready !== 1'b1)
            begin n_bad++; $display("FAIL b2b_overlap valid=%b ready=%b exp=1/1", resp_valid, req_ready); end
        @(posedge clk); #1; req_valid = 1'b0;
        got = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin got = c; break; end
        end
        n_cmp++; if (got !== 2 || resp_rdata !== 32'hCAFE_F00D)
            begin n_bad++; $display("FAIL b2b_load lat=%0d rdata=%h exp=2/cafef00d", got, resp_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat, wr, wacc, rl;
        logic we; logic [2:0] f3; logic [31:0] a, wd, exp_rd;
        logic exp_er; int exp_lat, exp_wr, bad_before;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            issue(1'b1, 3'b010, 32'(w * 4), wd, rd, er, lat, wr, wacc, rl);
            ref_mem[w] = wd;
        end
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? 32'h4000 + $urandom_range(0, 4095) : 32'($urandom_range(0, 63));
            wd = $urandom;
            exp_er = ref_err(we, f3, a);
            exp_rd = 32'h0; exp_wr = 0; exp_lat = 1;
            if (!exp_er) begin
                if (!we) begin
                    exp_rd = ref_load(ref_mem[a / 4], a, f3); exp_lat = 2;
                end else begin
                    ref_mem[a / 4] = ref_store(ref_mem[a / 4], a, f3, wd);
                    exp_wr = 1; exp_lat = (f3 == 3'b010) ? 1 : 2;
                end
            end
            issue(we, f3, a, wd, rd, er, lat, wr, wacc, rl);
            n_cmp++; if (rd !== exp_rd || er !== exp_er || lat !== exp_lat || wr !== exp_wr)
                begin n_bad++; $display("FAIL rand%0d we=%b f3=%b a=%h rdata=%h/%h err=%b/%b lat=%0d/%0d wr=%0d/%0d",
                                        t, we, f3, a, rd, exp_rd, er, exp_er, lat, exp_lat, wr, exp_wr); end
        end
        bad_before = n_bad;
        for (int w = 0; w < 16; w++) begin
            n_cmp++; if (mem[w] !== ref_mem[w])
                begin n_bad++; $display("FAIL rand_mem%0d got=%h exp=%h", w, mem[w], ref_mem[w]); end
        end
        if (n_bad != bad_before) $display("random memory image differs in %0d words", n_bad - bad_before);
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; rst = 1'b1;
        test_reset();
        test_loads();
        test_stores();
        test_reset_merge();
        test_errors();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
